uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, ports named clock and reset.
REQ-002 Parameter CLKS_PER_BIT, default 434, SHALL set clock cycles per serial bit (50 MHz / 115200 baud); legal values >= 4.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 data  output  8  last correctly received byte; drives the downstream byte shift register d input.
REQ-007 valid  output  1  one-cycle strobe when data updates; drives the shift register enable.
REQ-008 frame_err  output  1  one-cycle strobe on a bad stop bit.
REQ-009 parity_err  output  1  one-cycle strobe on parity mismatch; constant 0 when parity is compiled out.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a two-flop synchronizer; all logic SHALL use the synchronized value rxs.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
REQ-013 IDLE -> START when rxs==0; the cycle that sees rxs==0 is t0.
REQ-014 START SHALL sample rxs at t0+floor(CLKS_PER_BIT/2): 0 -> DATA; 1 -> IDLE as a glitch, with no strobe.
REQ-015 DATA bit i (0..7) SHALL be sampled at t0+floor(CLKS_PER_BIT/2)+(i+1)*CLKS_PER_BIT and stored at bit i of an internal shift register.
REQ-016 STOP SHALL be sampled one bit period after the last data bit (or after the parity bit).
REQ-017 On stop==1 with no parity error, data SHALL load the byte and valid SHALL pulse in the cycle after the stop sample; the FSM then enters IDLE.
REQ-018 On stop==0, frame_err SHALL pulse in the cycle after the stop sample; data SHALL hold its previous value, valid SHALL stay 0, and the FSM enters WAIT_IDLE.
REQ-019 WAIT_IDLE -> IDLE only after rxs==1 is seen; a line held low (break) SHALL produce exactly one frame_err.
REQ-020 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and reload at each sample point, with no drift across a frame.
REQ-021 A new start bit SHALL be accepted in the first cycle after returning to IDLE, so back-to-back frames are received without loss.
REQ-022 valid, frame_err and parity_err SHALL be mutually exclusive and never high for two consecutive cycles.

Reset
REQ-023 Reset SHALL force state IDLE, data=8'h00, valid=0, frame_err=0, parity_err=0, busy=0, and both synchronizer flops to 1.
REQ-024 Reset mid-frame SHALL abandon the frame with no strobe; the next falling edge after reset starts a fresh frame.
REQ-025 data SHALL also initialise to 8'h00 at configuration (initial block) for FPGA power-up.

Configuration
REQ-026 Macro UART_BYTE_RX_PARITY_EN defined: one even-parity bit SHALL follow bit 7 (PARITY state); on mismatch parity_err pulses, data holds, valid stays 0, and the stop bit is still checked (a stop failure also routes to WAIT_IDLE, with frame_err taking precedence over parity_err).
REQ-027 Macro undefined: the PARITY state and its logic SHALL be absent, the frame is 8N1, and parity_err is tied to 0.

Verification (CLKS_PER_BIT=4)
REQ-028 Frame 0xA5, stop=1 -> valid pulses once, 1 cycle after the stop sample, with data=8'hA5; frame_err=0.
REQ-029 Frames 0x01 then 0xFF back-to-back with no idle gap -> two valid pulses 40 cycles apart, data 8'h01 then 8'hFF.
REQ-030 Low glitch of 1 cycle on rx in IDLE -> FSM returns to IDLE, no strobe, data unchanged.
REQ-031 Frame 0x3C with stop=0, then rx held low for 100 cycles -> exactly one frame_err, data keeps its prior value, and busy stays high until rx returns high.
REQ-032 Reset asserted during bit 4 of a frame -> no valid, outputs at reset values; a following 0x5A frame is received correctly.
REQ-033 With UART_BYTE_RX_PARITY_EN: 0x07 with parity bit 1 -> valid, data=8'h07; the same byte with parity bit 0 -> one parity_err and no valid.

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with two-flop input synchronizer and mid-bit sampling.
// Define UART_BYTE_RX_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_BYTE_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  logic          rx_meta_reg;
  logic          rxs;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  // Power-up value for FPGA configuration, independent of reset.
  logic [7:0]    data_reg = 8'h00;
  logic [7:0]    data_next;
  logic          valid_reg, valid_next;
  logic          ferr_reg, ferr_next;
  logic          tick;
`ifdef UART_BYTE_RX_PARITY_EN
  logic          par_bad_reg, par_bad_next;
  logic          perr_reg, perr_next;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rxs         <= 1'b1;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rxs         <= rx_meta_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
    end
  end

`ifdef UART_BYTE_RX_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      par_bad_reg <= 1'b0;
      perr_reg    <= 1'b0;
    end else begin
      par_bad_reg <= par_bad_next;
      perr_reg    <= perr_next;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
    par_bad_next = par_bad_reg;
    perr_next    = 1'b0;
`endif
    tick = (cnt_reg == '0);

    // Every sample point reloads a full bit period, so timing never drifts.
    if (state_reg != IDLE && state_reg != WAIT_IDLE)
      cnt_next = tick ? FULL_M1 : cnt_reg - CW'(1);

    case (state_reg)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = HALF_M1;
        end
      end
      START: begin
        if (tick) begin
          bit_next   = 3'd0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next[bit_reg] = rxs;
          bit_next = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_BYTE_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_BYTE_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bad_next = rxs ^ (^shift_reg);
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!rxs) begin
            ferr_next  = 1'b1;
            state_next = WAIT_IDLE;
`ifdef UART_BYTE_RX_PARITY_EN
          end else if (par_bad_reg) begin
            perr_next  = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) stays here so it reports only one frame error.
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = ferr_reg;
  assign busy      = (state_reg != IDLE);
`ifdef UART_BYTE_RX_PARITY_EN
  assign parity_err = perr_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx at CLKS_PER_BIT=4: stimulus pushes expected strobes,
// a negedge monitor pops and compares kind, data and arrival cycle.
module tb_uart_byte_rx;
  localparam int C = 4;
  localparam int H = C / 2;
`ifdef UART_BYTE_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Strobe cycle relative to the cycle rx falls: 2 sync flops, half bit, remaining bits, 1 output reg.
  localparam int LAT = 3 + H + (NBITS - 1) * C;
  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] held  = 8'h00;
  logic       prev_strobe = 1'b0;

  uart_byte_rx #(.CLKS_PER_BIT(C)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; leaves rx at the stop value and returns at a negedge.
  task automatic send(input logic [7:0] b, input logic par, input logic stop, input logic [2:0] kind);
    exp_t        e;
    logic [10:0] bits;
    if (kind == K_VALID) held = b;
    e.kind = kind;
    e.data = held;
    e.cyc  = cyc + LAT;
    sb.push_back(e);
`ifdef UART_BYTE_RX_PARITY_EN
    bits = {stop, par, b, 1'b0};
`else
    bits = {par, stop, b, 1'b0};
`endif
    $display("send byte=%02h par=%b stop=%b expect kind=%b at cycle %0d", b, par, stop, kind, e.cyc);
    for (int i = 0; i < NBITS; i++) begin
      rx = bits[i];
      repeat (C) @(negedge clock);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t        e;
    logic [2:0]  k;
    int          n;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_strobe = 1'b0;
      end else begin
        k = {parity_err, frame_err, valid};
        n = int'(valid) + int'(frame_err) + int'(parity_err);
        if (n != 0) begin
          check("strobe_exclusive", n, 1);
          check("strobe_not_consecutive", {31'd0, prev_strobe}, 0);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got kind=%b data=%02h expected none (cycle %0d)", k, data, cyc);
          end else begin
            e = sb.pop_front();
            $display("strobe kind=%b data=%02h cycle=%0d", k, data, cyc);
            check("strobe_kind", {29'd0, k}, {29'd0, e.kind});
            check("strobe_data", {24'd0, data}, {24'd0, e.data});
            check("strobe_cycle", cyc, e.cyc);
          end
        end
        prev_strobe = (n != 0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    check("reset_data", {24'd0, data}, 0);
    check("reset_valid", {31'd0, valid}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    check("reset_parity_err", {31'd0, parity_err}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    send(8'hA5, 1'b0, 1'b1, K_VALID);
    repeat (8) @(negedge clock);

    // Back-to-back frames: strobes 40 cycles apart through the cycle check.
    send(8'h01, 1'b1, 1'b1, K_VALID);
    send(8'hFF, 1'b0, 1'b1, K_VALID);
    repeat (8) @(negedge clock);

    // One-cycle low glitch in IDLE.
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (10) @(negedge clock);
    $display("glitch: busy=%b data=%02h", busy, data);
    check("glitch_busy", {31'd0, busy}, 0);
    check("glitch_data", {24'd0, data}, {24'd0, held});

    // Bad stop bit followed by a 100-cycle break.
    send(8'h3C, 1'b0, 1'b0, K_FERR);
    rx = 1'b0;
    repeat (100) @(negedge clock);
    $display("break: busy=%b data=%02h", busy, data);
    check("break_busy_high", {31'd0, busy}, 1);
    rx = 1'b1;
    repeat (5) @(negedge clock);
    check("break_release_busy", {31'd0, busy}, 0);
    check("break_data_held", {24'd0, data}, {24'd0, held});

    // Reset during bit 4 of byte 0x96 (bits 0..3 = 0,1,1,0; bit 4 = 1).
    rx = 1'b0; repeat (C) @(negedge clock);
    rx = 1'b0; repeat (C) @(negedge clock);
    rx = 1'b1; repeat (C) @(negedge clock);
    rx = 1'b1; repeat (C) @(negedge clock);
    rx = 1'b0; repeat (C) @(negedge clock);
    rx = 1'b1; repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    $display("midframe reset: data=%02h valid=%b busy=%b", data, valid, busy);
    check("midrst_data", {24'd0, data}, 0);
    check("midrst_valid", {31'd0, valid}, 0);
    check("midrst_frame_err", {31'd0, frame_err}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    held  = 8'h00;
    repeat (4) @(negedge clock);
    send(8'h5A, 1'b0, 1'b1, K_VALID);
    repeat (8) @(negedge clock);

`ifdef UART_BYTE_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, K_VALID);
    repeat (4) @(negedge clock);
    send(8'h07, 1'b0, 1'b1, K_PERR);
    repeat (4) @(negedge clock);
`endif

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
